mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_W, default 32: width of addresses and data words.
REQ-002 Parameter CPUS, default 2: number of cores sharing the RAM port; fixed at 2 for this revision.
REQ-003 Port CLK  input  1: single clock; all state updates on rising edge.
REQ-004 Port nRST  input  1: reset, asynchronous assert, active-low.
REQ-005 Port iREN  input  2: per-core instruction read request, bit n = core n.
REQ-006 Port iaddr0, iaddr1  input  WORD_W: per-core instruction addresses.
REQ-007 Port dREN, dWEN  input  2 each: per-core data read and write requests.
REQ-008 Port daddr0, daddr1, dstore0, dstore1  input  WORD_W: per-core data address and store data.
REQ-009 Port iwait, dwait  output  2 each: per-requester stall; low for exactly the completion cycle.
REQ-010 Port iload, dload  output  WORD_W: ramload broadcast; valid for the requester whose wait is low.
REQ-011 Port ramREN, ramWEN  output  1 each: RAM read and write strobes.
REQ-012 Port ramaddr, ramstore  output  WORD_W: RAM address and write data.
REQ-013 Port ramload  input  WORD_W: RAM read data.
REQ-014 Port ramstate  input  2: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-015 FSM states: IDLE and SERVE; grant register holds {type D/I, core} and is captured on the IDLE->SERVE edge.
REQ-016 IDLE: with any active request, SHALL latch a grant and go to SERVE next cycle; with no request, SHALL stay in IDLE.
REQ-017 Priority: any data request (dREN|dWEN) beats any instruction request.
REQ-018 Within a type, the core equal to the round-robin pointer rr wins on conflict; otherwise the sole requester wins.
REQ-019 rr SHALL toggle to the other core after every completed transaction, whatever its type.
REQ-020 A core with both dWEN and dREN high SHALL be served as a write.
REQ-021 In SERVE, the granted request's address, store data, and REN/WEN drive the RAM outputs combinationally; in IDLE all RAM outputs are 0.
REQ-022 Completion: in SERVE with ramstate==ACCESS, the granted wait bit SHALL be 0 that cycle and the FSM SHALL return to IDLE.
REQ-023 Minimum latency: request to wait-low is 2 cycles (IDLE grant cycle plus one SERVE cycle with ACCESS).
REQ-024 All wait bits not completing SHALL be 1, including in IDLE.
REQ-025 Abort: if the granted request deasserts during SERVE, the FSM SHALL return to IDLE next cycle with no wait-low, and rr SHALL be unchanged.
REQ-026 Error: ramstate==ERROR in SERVE SHALL return the FSM to IDLE without completion and without changing rr; the request re-arbitrates.
REQ-027 Requests that change address or type while granted SHALL NOT re-arbitrate; the grant holds until completion, abort, or error.
REQ-028 iload and dload SHALL equal ramload at all times.

Reset
REQ-029 On nRST low, at any time including mid-transaction: state=IDLE, rr=0, grant cleared, ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=2'b11.
REQ-030 After reset release, the first arbitration SHALL occur on the first rising edge with nRST high.

Verification
REQ-031 Test 1: core0 iREN, iaddr0=0x100; ramstate ACCESS on the first SERVE cycle. Expect ramREN=1 and ramaddr=0x100 in SERVE, iwait[0]=0 in the same cycle, iload=ramload, and rr 0->1.
REQ-032 Test 2: same cycle, dWEN[1] with daddr1=0x200, dstore1=0xDEADBEEF, plus iREN[0]. Expect the data write served first (ramWEN=1, ramstore=0xDEADBEEF), then the instruction read.
REQ-033 Test 3: dREN on both cores continuously, ACCESS each SERVE cycle. Expect grants alternating core0, core1, core0, with dwait bits pulsing low alternately every 2 cycles.
REQ-034 Test 4: ramstate BUSY for 3 SERVE cycles, then ACCESS. Expect the wait bit to stay high 3 cycles, go low on the 4th, and the RAM outputs to stay stable throughout.
REQ-035 Test 5: deassert the granted dREN mid-SERVE. Expect return to IDLE, no wait-low, rr unchanged. Then force ERROR on a new request and expect the same behaviour.
REQ-036 Test 6: assert nRST low during SERVE with ramWEN=1. Expect ramWEN=0, waits=11, and IDLE immediately (asynchronous), with rr=0 after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-core RAM arbiter: data requests beat instruction requests, round-robin between cores.
// One transaction is in flight at a time; wait bits drop only on the ACCESS cycle.
module mem_arbiter #(
  parameter int WORD_W = 32,
  parameter int CPUS   = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [CPUS-1:0]   iREN,
  input  logic [WORD_W-1:0] iaddr0,
  input  logic [WORD_W-1:0] iaddr1,
  input  logic [CPUS-1:0]   dREN,
  input  logic [CPUS-1:0]   dWEN,
  input  logic [WORD_W-1:0] daddr0,
  input  logic [WORD_W-1:0] daddr1,
  input  logic [WORD_W-1:0] dstore0,
  input  logic [WORD_W-1:0] dstore1,
  output logic [CPUS-1:0]   iwait,
  output logic [CPUS-1:0]   dwait,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic {IDLE, SERVE} state_e;

  state_e state_q, state_d;
  logic   rr_q, rr_d;
  logic   gdata_q, gdata_d;
  logic   gcore_q, gcore_d;

  logic [CPUS-1:0]   dreq;
  logic [CPUS-1:0]   pick;
  logic              arb_data;
  logic              arb_core;
  logic              g_active;
  logic [WORD_W-1:0] g_addr;
  logic [WORD_W-1:0] g_store;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      gdata_q <= 1'b0;
      gcore_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gdata_q <= gdata_d;
      gcore_q <= gcore_d;
    end
  end

  // Arbitration: pick the request class first, then favour the rr core if it is asking.
  always_comb begin
    dreq     = dREN | dWEN;
    arb_data = |dreq;
    pick     = arb_data ? dreq : iREN;
    arb_core = pick[rr_q] ? rr_q : ~rr_q;
  end

  // The granted request is followed live so an abort or a write/read flip is seen at once.
  always_comb begin
    g_active = gdata_q ? (dREN[gcore_q] | dWEN[gcore_q]) : iREN[gcore_q];
    g_addr   = gdata_q ? (gcore_q ? daddr1 : daddr0) : (gcore_q ? iaddr1 : iaddr0);
    g_store  = gcore_q ? dstore1 : dstore0;
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gdata_d  = gdata_q;
    gcore_d  = gcore_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;

    case (state_q)
      IDLE: begin
        if (arb_data || (|iREN)) begin
          state_d = SERVE;
          gdata_d = arb_data;
          gcore_d = arb_core;
        end
      end
      SERVE: begin
        ramaddr = g_addr;
        if (gdata_q) begin
          ramWEN   = dWEN[gcore_q];
          ramREN   = dREN[gcore_q] & ~dWEN[gcore_q];
          ramstore = g_store;
        end else begin
          ramREN = iREN[gcore_q];
        end

        // Abort and error both drop back without touching rr so the core keeps its turn.
        if (!g_active || (ramstate == RAM_ERROR)) begin
          state_d = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          state_d = IDLE;
          rr_d    = ~rr_q;
          if (gdata_q) dwait[gcore_q] = 1'b0;
          else         iwait[gcore_q] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions are queued as requests are
// driven and retired by a monitor whenever a wait bit drops.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int         W      = 32;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;
  localparam logic [W-1:0] LOAD_K = 32'h5A5A_0000;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic [1:0]   iREN, dREN, dWEN;
  logic [W-1:0] iaddr0, iaddr1, daddr0, daddr1, dstore0, dstore1;
  logic [1:0]   iwait, dwait;
  logic [W-1:0] iload, dload;
  logic         ramREN, ramWEN;
  logic [W-1:0] ramaddr, ramstore, ramload;
  logic [1:0]   ramstate;

  always #5 CLK = ~CLK;

  // RAM model: read data is a fixed scramble of the address.
  assign ramload = ramaddr ^ LOAD_K;

  mem_arbiter #(.WORD_W(W), .CPUS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr0(iaddr0), .iaddr1(iaddr1),
    .dREN(dREN), .dWEN(dWEN), .daddr0(daddr0), .daddr1(daddr1),
    .dstore0(dstore0), .dstore1(dstore1),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  typedef struct {
    bit           d;
    bit           c;
    logic [W-1:0] addr;
    bit           wen;
    logic [W-1:0] store;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   mrr    = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit d, input bit c, input logic [W-1:0] a, input bit w,
                      input logic [W-1:0] s);
    exp_t e;
    e.d = d; e.c = c; e.addr = a; e.wen = w; e.store = s;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the completion cycle.
  task automatic wait_done(input bit d, input bit c, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #3;
      if ((d ? dwait[c] : iwait[c]) == 1'b0) seen = 1'b1;
      step();
    end
    check(tag, 64'(seen), 64'(1));
    if (seen) mrr = ~mrr;
  endtask

  task automatic idle_outputs(input string tag);
    check({tag, "_ren"},   64'(ramREN),  64'(0));
    check({tag, "_wen"},   64'(ramWEN),  64'(0));
    check({tag, "_addr"},  64'(ramaddr), 64'(0));
    check({tag, "_iwait"}, 64'(iwait),   64'(2'b11));
    check({tag, "_dwait"}, 64'(dwait),   64'(2'b11));
  endtask

  always @(negedge CLK) begin
    if (nRST) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 2; c++) begin
          if ((d != 0 ? dwait[c] : iwait[c]) == 1'b0) begin
            check("done_expected", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
              exp_t e;
              e = sb.pop_front();
              check("done_type", 64'(d), 64'(e.d));
              check("done_core", 64'(c), 64'(e.c));
              check("done_addr", 64'(ramaddr), 64'(e.addr));
              check("done_wen",  64'(ramWEN), 64'(e.wen));
              check("done_ren",  64'(ramREN), 64'(!e.wen));
              if (e.wen) check("done_store", 64'(ramstore), 64'(e.store));
              check("done_load", 64'(d != 0 ? dload : iload), 64'(e.addr ^ LOAD_K));
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iREN = 2'b11; dREN = 2'b11; dWEN = 2'b11;
    iaddr0 = 32'h11; iaddr1 = 32'h22; daddr0 = 32'h33; daddr1 = 32'h44;
    dstore0 = 32'h55; dstore1 = 32'h66; ramstate = ACCESS;
    repeat (2) @(posedge CLK);
    #4;
    idle_outputs("reset");
    check("reset_store", 64'(ramstore), 64'(0));

    // Test 1: lone instruction read, ACCESS on the first SERVE cycle.
    step();
    iREN = 2'b00; dREN = 2'b00; dWEN = 2'b00;
    nRST = 1'b1;
    iaddr0 = 32'h100; iREN = 2'b01; ramstate = ACCESS;
    push(0, 0, 32'h100, 0, 0);
    #3 idle_outputs("t1_idle");
    step();
    #3;
    check("t1_ren",   64'(ramREN),  64'(1));
    check("t1_addr",  64'(ramaddr), 64'(32'h100));
    check("t1_iwait", 64'(iwait),   64'(2'b10));
    check("t1_iload", 64'(iload),   64'(32'h100 ^ LOAD_K));
    step();
    iREN = 2'b00;
    mrr = ~mrr;

    // Test 2: data write on core1 wins over instruction read on core0.
    daddr1 = 32'h200; dstore1 = 32'hDEADBEEF; dWEN = 2'b10;
    iaddr0 = 32'h104; iREN = 2'b01;
    push(1, 1, 32'h200, 1, 32'hDEADBEEF);
    push(0, 0, 32'h104, 0, 0);
    wait_done(1, 1, "t2_write_done");
    dWEN = 2'b00;
    wait_done(0, 0, "t2_read_done");
    iREN = 2'b00;

    // rr is 1 here: both cores reading instructions, core1 first.
    iaddr0 = 32'h300; iaddr1 = 32'h304; iREN = 2'b11;
    push(0, 1, 32'h304, 0, 0);
    push(0, 0, 32'h300, 0, 0);
    wait_done(0, 1, "rr_core1_done");
    iREN = 2'b01;
    wait_done(0, 0, "rr_core0_done");
    iREN = 2'b00;

    // Reset with requests pending, then Test 3 from rr=0.
    nRST = 1'b0; dREN = 2'b11;
    #3 idle_outputs("rst2");
    step();
    nRST = 1'b1; mrr = 1'b0;
    daddr0 = 32'h800; daddr1 = 32'h804; ramstate = ACCESS;
    push(1, 0, 32'h800, 0, 0); push(1, 1, 32'h804, 0, 0);
    push(1, 0, 32'h800, 0, 0); push(1, 1, 32'h804, 0, 0);
    for (int k = 0; k < 8; k++) begin
      #3;
      check("t3_dwait", 64'(dwait),
            64'((k % 2 == 0) ? 2'b11 : (((k / 2) % 2 == 0) ? 2'b10 : 2'b01)));
      step();
    end
    dREN = 2'b00;

    // Test 4: three BUSY cycles, then ACCESS.
    iaddr1 = 32'h400; iREN = 2'b10; ramstate = BUSY;
    #3 idle_outputs("t4_idle");
    step();
    for (int k = 0; k < 3; k++) begin
      #3;
      check("t4_busy_iwait", 64'(iwait),   64'(2'b11));
      check("t4_busy_ren",   64'(ramREN),  64'(1));
      check("t4_busy_addr",  64'(ramaddr), 64'(32'h400));
      step();
    end
    ramstate = ACCESS;
    push(0, 1, 32'h400, 0, 0);
    #3 check("t4_done_iwait", 64'(iwait), 64'(2'b01));
    step();
    iREN = 2'b00; mrr = ~mrr;

    // Test 5a: granted dREN drops mid-SERVE.
    daddr0 = 32'h500; dREN = 2'b01; ramstate = BUSY;
    #3 idle_outputs("t5_idle");
    step();
    #3;
    check("t5_ren",   64'(ramREN), 64'(1));
    check("t5_dwait", 64'(dwait),  64'(2'b11));
    step();
    dREN = 2'b00;
    #3;
    check("t5_abort_dwait", 64'(dwait),  64'(2'b11));
    check("t5_abort_ren",   64'(ramREN), 64'(0));
    step();
    #3 idle_outputs("t5_after_abort");
    step();

    // Test 5b: ERROR on a contested grant; rr (1) must still pick core1 afterwards.
    daddr0 = 32'h510; daddr1 = 32'h514; dREN = 2'b11; ramstate = ERROR;
    #3 check("t5e_idle_dwait", 64'(dwait), 64'(2'b11));
    step();
    #3;
    check("t5e_grant_addr", 64'(ramaddr), 64'(32'h514));
    check("t5e_err_dwait",  64'(dwait),   64'(2'b11));
    step();
    ramstate = ACCESS;
    #3 idle_outputs("t5e_after_err");
    step();
    push(1, 1, 32'h514, 0, 0);
    #3;
    check("t5e_regrant_addr", 64'(ramaddr), 64'(32'h514));
    check("t5e_done_dwait",   64'(dwait),   64'(2'b01));
    step();
    dREN = 2'b01; mrr = ~mrr;
    push(1, 0, 32'h510, 0, 0);
    wait_done(1, 0, "t5e_core0_done");
    dREN = 2'b00;

    // Test 6: reset mid-write; dREN+dWEN on one core is a write. rr is 1 going in.
    daddr0 = 32'h700; dstore0 = 32'hCAFEF00D; dREN = 2'b01; dWEN = 2'b01; ramstate = BUSY;
    #3 idle_outputs("t6_idle");
    step();
    #3;
    check("t6_wen",   64'(ramWEN),   64'(1));
    check("t6_ren",   64'(ramREN),   64'(0));
    check("t6_store", 64'(ramstore), 64'(32'hCAFEF00D));
    check("t6_addr",  64'(ramaddr),  64'(32'h700));
    nRST = 1'b0;
    #2;
    idle_outputs("t6_async_rst");
    check("t6_rst_store", 64'(ramstore), 64'(0));
    step();
    dREN = 2'b00; dWEN = 2'b11; daddr1 = 32'h704; dstore1 = 32'h12345678;
    ramstate = ACCESS; nRST = 1'b1; mrr = 1'b0;
    push(1, 0, 32'h700, 1, 32'hCAFEF00D);
    #3 idle_outputs("t6_release");
    step();
    #3;
    check("t6_rr0_dwait", 64'(dwait),   64'(2'b10));
    check("t6_rr0_addr",  64'(ramaddr), 64'(32'h700));
    step();
    dWEN = 2'b00; mrr = ~mrr;

    repeat (3) step();
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
